rv64_gpr_regfile_mp: RTL and testbench
======================================

RV64_GPR_REGFILE_MP -- requirements
Module: rv64_gpr_regfile_mp

Interface
REQ-001 The block SHALL provide parameter XLEN, default 64, data width of each register.
REQ-002 The block SHALL provide parameter REG_NUM, default 32, number of architectural registers; x0 is register 0.
REQ-003 The block SHALL provide parameter ADDR_W, default 5, register index width; REG_NUM <= 2**ADDR_W.
REQ-004 The block SHALL provide parameter NR, default 4, number of read ports.
REQ-005 The block SHALL provide parameter NW, default 2, number of write ports.
REQ-006 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-007 Port: rst  input  1  reset, asynchronous, active-high.
REQ-008 Port: rd_idx_i  input  NR*ADDR_W  read indices, port p at bits [p*ADDR_W +: ADDR_W].
REQ-009 Port: rd_data_o  output  NR*XLEN  read data, port p at bits [p*XLEN +: XLEN].
REQ-010 Port: rd_busy_o  output  NR  per read port, register has an outstanding producer.
REQ-011 Port: wr_valid_i  input  NW  per write port, write request.
REQ-012 Port: wr_idx_i  input  NW*ADDR_W  write indices.
REQ-013 Port: wr_data_i  input  NW*XLEN  write data.
REQ-014 Port: iss_valid_i  input  1  issue: mark iss_idx_i busy.
REQ-015 Port: iss_idx_i  input  ADDR_W  destination of issued instruction.
REQ-016 Port: flush_i  input  1  clear all busy bits (pipeline flush).
REQ-017 Port: busy_cnt_o  output  $clog2(REG_NUM+1)  registered count of busy registers.

Function
REQ-018 Writes SHALL commit at rising clk when wr_valid_i[w]=1 and wr_idx_i!=0; writes to x0 are dropped.
REQ-019 Multiple valid write ports targeting the same index in one cycle: highest-numbered port SHALL win.
REQ-020 Reads SHALL be combinational, zero latency.
REQ-021 Read of index 0 SHALL return 0 regardless of writes or bypass.
REQ-022 Bypass: read index matching a same-cycle valid write (index != 0) SHALL return that write's data, highest-numbered matching port winning; bypass SHALL be gated by wr_valid_i (an invalid write never bypasses).
REQ-023 Otherwise reads SHALL return array contents.
REQ-024 Scoreboard: one busy bit per register; busy[0] SHALL be constant 0.
REQ-025 At rising clk with flush_i=1: all busy bits SHALL clear; same-cycle issue ignored; register writes still commit.
REQ-026 At rising clk with flush_i=0: busy bit of each valid, nonzero write index SHALL clear; then, if iss_valid_i=1 and iss_idx_i!=0, busy[iss_idx_i] SHALL set (set wins over same-cycle clear of same index).
REQ-027 rd_busy_o[p] SHALL equal busy[rd_idx] AND NOT (bypass hit on port p); 0 for index 0.
REQ-028 busy_cnt_o SHALL equal the population count of busy bits, updated in the same edge as the bits (one-cycle visibility, no combinational path from inputs).
REQ-029 Index values >= REG_NUM SHALL read 0, never write, never set busy.

Reset
REQ-030 rst=1 SHALL immediately clear all registers to 0, all busy bits to 0, busy_cnt_o to 0, independent of clk.
REQ-031 rst asserted mid-operation SHALL discard any same-cycle write/issue; first update occurs at the first rising clk after rst deasserts.
REQ-032 While rst=1, rd_data_o SHALL reflect bypass of valid writes combinationally but no state SHALL change.

Verification
REQ-033 Reset then read all 32 registers on all ports -> every rd_data_o=0, rd_busy_o=0, busy_cnt_o=0.
REQ-034 Write x5=0xDEADBEEF_00000001 on port 0 with rd_idx port 2 =5 same cycle -> port 2 reads bypassed value; next cycle reads array value identically; wr_valid=0 with idx=5, data=0x1234 -> no bypass.
REQ-035 Port 0 and port 1 both write x7 (0x11, 0x22) -> x7 reads 0x22 after edge; write x0=0xFF -> x0 reads 0, busy_cnt unchanged.
REQ-036 Issue x3, x4 on consecutive cycles -> busy_cnt_o 1 then 2, rd_busy for x3=1; write x3 -> rd_busy for x3 drops same cycle, busy_cnt 1 after edge; issue x4 while writing x4 -> x4 stays busy.
REQ-037 With x3,x4,x9 busy, flush_i=1 with iss_valid_i=1 idx 10 -> after edge busy_cnt_o=0, x10 not busy.
REQ-038 Assert rst asynchronously between edges with registers populated and busy bits set -> outputs zero before next edge; no stale write lands after deassertion.

Source files
------------

// File: rtl/rv64_gpr_regfile_mp.sv
// rv64_gpr_regfile_mp: multi-ported integer register file with write bypass and busy scoreboard
module rv64_gpr_regfile_mp #(
  parameter int XLEN    = 64,
  parameter int REG_NUM = 32,
  parameter int ADDR_W  = 5,
  parameter int NR      = 4,
  parameter int NW      = 2
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NR*ADDR_W-1:0]           rd_idx_i,
  output logic [NR*XLEN-1:0]             rd_data_o,
  output logic [NR-1:0]                  rd_busy_o,
  input  logic [NW-1:0]                  wr_valid_i,
  input  logic [NW*ADDR_W-1:0]           wr_idx_i,
  input  logic [NW*XLEN-1:0]             wr_data_i,
  input  logic                           iss_valid_i,
  input  logic [ADDR_W-1:0]              iss_idx_i,
  input  logic                           flush_i,
  output logic [$clog2(REG_NUM+1)-1:0]   busy_cnt_o
);
  localparam int CW = $clog2(REG_NUM + 1);
  logic [XLEN-1:0]    regs [REG_NUM];
  logic [REG_NUM-1:0] busy, busy_nxt;
  logic [CW-1:0]      cnt_nxt;
  // x0 and indices past the array are never real registers
  function automatic logic ok(input logic [ADDR_W-1:0] i);
    return i != '0 && int'(i) < REG_NUM;
  endfunction
  // next scoreboard: flush clears all, else writebacks clear then issue sets
  always_comb begin
    busy_nxt = busy;
    if (flush_i) busy_nxt = '0;
    else begin
      for (int w = 0; w < NW; w++)
        if (wr_valid_i[w] && ok(wr_idx_i[w*ADDR_W +: ADDR_W])) busy_nxt[wr_idx_i[w*ADDR_W +: ADDR_W]] = 1'b0;
      if (iss_valid_i && ok(iss_idx_i)) busy_nxt[iss_idx_i] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
    cnt_nxt = '0;
    for (int r = 0; r < REG_NUM; r++) cnt_nxt = cnt_nxt + CW'(busy_nxt[r]);
  end
  // commit writes (later port overrides earlier) and scoreboard state
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      regs       <= '{default: '0};
      busy       <= '0;
      busy_cnt_o <= '0;
    end else begin
      for (int w = 0; w < NW; w++)
        if (wr_valid_i[w] && ok(wr_idx_i[w*ADDR_W +: ADDR_W])) regs[wr_idx_i[w*ADDR_W +: ADDR_W]] <= wr_data_i[w*XLEN +: XLEN];
      busy       <= busy_nxt;
      busy_cnt_o <= cnt_nxt;
    end
  for (genvar p = 0; p < NR; p++) begin : g_rd
    logic [ADDR_W-1:0] ri;
    logic              hit;
    logic [XLEN-1:0]   bdata;
    assign ri = rd_idx_i[p*ADDR_W +: ADDR_W];
    // same-cycle write bypass, highest matching port wins
    always_comb begin
      hit   = 1'b0;
      bdata = '0;
      for (int w = 0; w < NW; w++)
        if (wr_valid_i[w] && wr_idx_i[w*ADDR_W +: ADDR_W] == ri) begin
          hit   = 1'b1;
          bdata = wr_data_i[w*XLEN +: XLEN];
        end
    end
    assign rd_data_o[p*XLEN +: XLEN] = !ok(ri) ? '0 : hit ? bdata : regs[ri];
    assign rd_busy_o[p] = ok(ri) && busy[ri] && !hit;
  end
endmodule

// File: tb/tb_rv64_gpr_regfile_mp.sv
// tb_rv64_gpr_regfile_mp: directed self-checking bench for rv64_gpr_regfile_mp
module tb_rv64_gpr_regfile_mp;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [19:0]   rd_idx_i = '0;
  logic [255:0]  rd_data_o;
  logic [3:0]    rd_busy_o;
  logic [1:0]    wr_valid_i = '0;
  logic [9:0]    wr_idx_i = '0;
  logic [127:0]  wr_data_i = '0;
  logic          iss_valid_i = 1'b0;
  logic [4:0]    iss_idx_i = '0;
  logic          flush_i = 1'b0;
  logic [5:0]    busy_cnt_o;
  int            tests = 0;
  int            fails = 0;

  rv64_gpr_regfile_mp dut (
    .clk(clk), .rst(rst), .rd_idx_i(rd_idx_i), .rd_data_o(rd_data_o), .rd_busy_o(rd_busy_o),
    .wr_valid_i(wr_valid_i), .wr_idx_i(wr_idx_i), .wr_data_i(wr_data_i),
    .iss_valid_i(iss_valid_i), .iss_idx_i(iss_idx_i), .flush_i(flush_i), .busy_cnt_o(busy_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic rsel(int p, logic [4:0] idx);
    rd_idx_i[p*5 +: 5] = idx;
  endtask

  task automatic wr(int w, logic [4:0] idx, logic [63:0] d);
    wr_valid_i[w]         = 1'b1;
    wr_idx_i[w*5 +: 5]    = idx;
    wr_data_i[w*64 +: 64] = d;
  endtask

  task automatic iss(logic [4:0] idx);
    iss_valid_i = 1'b1;
    iss_idx_i   = idx;
  endtask

  task automatic idle();
    wr_valid_i  = '0;
    iss_valid_i = 1'b0;
    flush_i     = 1'b0;
  endtask

  function automatic logic [63:0] rd(int p);
    return rd_data_o[p*64 +: 64];
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #12;
    for (int i = 0; i < 32; i++) begin
      for (int p = 0; p < 4; p++) rsel(p, 5'(i));
      #1;
      for (int p = 0; p < 4; p++) begin
        check($sformatf("reset_data_x%0d_p%0d", i, p), rd(p), 64'h0);
        check($sformatf("reset_busy_x%0d_p%0d", i, p), 64'(rd_busy_o[p]), 64'h0);
      end
    end
    check("reset_cnt", 64'(busy_cnt_o), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    // bypass on write to x5
    wr(0, 5, 64'hDEADBEEF_00000001);
    rsel(2, 5);
    #1 check("bypass_x5", rd(2), 64'hDEADBEEF_00000001);
    cyc();
    idle();
    #1 check("array_x5", rd(2), 64'hDEADBEEF_00000001);
    wr_idx_i[4:0] = 5;
    wr_data_i[63:0] = 64'h1234;
    #1 check("no_bypass_invalid", rd(2), 64'hDEADBEEF_00000001);
    // same index on both ports, higher port wins
    wr(0, 7, 64'h11);
    wr(1, 7, 64'h22);
    rsel(0, 7);
    #1 check("bypass_prio_x7", rd(0), 64'h22);
    cyc();
    idle();
    #1 check("commit_prio_x7", rd(0), 64'h22);
    // x0 write dropped
    wr(0, 0, 64'hFF);
    rsel(1, 0);
    #1 check("x0_bypass", rd(1), 64'h0);
    cyc();
    idle();
    #1 check("x0_after", rd(1), 64'h0);
    check("x0_cnt", 64'(busy_cnt_o), 64'd0);
    // scoreboard issue and writeback
    iss(3);
    cyc();
    check("cnt_after_x3", 64'(busy_cnt_o), 64'd1);
    iss(4);
    rsel(0, 3);
    #1 check("busy_x3", 64'(rd_busy_o[0]), 64'd1);
    cyc();
    idle();
    #1 check("cnt_after_x4", 64'(busy_cnt_o), 64'd2);
    wr(0, 3, 64'h33);
    #1 check("busy_x3_bypassed", 64'(rd_busy_o[0]), 64'd0);
    check("data_x3_bypassed", rd(0), 64'h33);
    cyc();
    idle();
    rsel(1, 4);
    #1 check("cnt_after_wb_x3", 64'(busy_cnt_o), 64'd1);
    check("busy_x3_cleared", 64'(rd_busy_o[0]), 64'd0);
    check("busy_x4_still", 64'(rd_busy_o[1]), 64'd1);
    iss(4);
    wr(1, 4, 64'h44);
    cyc();
    idle();
    #1 check("cnt_x4_reissued", 64'(busy_cnt_o), 64'd1);
    check("busy_x4_reissued", 64'(rd_busy_o[1]), 64'd1);
    check("data_x4", rd(1), 64'h44);
    // flush overrides same-cycle issue, writes still commit
    iss(3);
    cyc();
    iss(9);
    cyc();
    idle();
    #1 check("cnt_three_busy", 64'(busy_cnt_o), 64'd3);
    flush_i = 1'b1;
    iss(10);
    wr(0, 12, 64'hC12);
    cyc();
    idle();
    rsel(2, 10);
    rsel(3, 12);
    #1 check("flush_cnt", 64'(busy_cnt_o), 64'd0);
    check("flush_x10_free", 64'(rd_busy_o[2]), 64'd0);
    check("flush_write_x12", rd(3), 64'hC12);
    // asynchronous reset mid-cycle
    iss(5);
    cyc();
    iss(6);
    cyc();
    idle();
    rsel(0, 5);
    rsel(1, 6);
    #1 check("pre_rst_cnt", 64'(busy_cnt_o), 64'd2);
    check("pre_rst_busy_x6", 64'(rd_busy_o[1]), 64'd1);
    wr(0, 5, 64'hBAD);
    iss(8);
    #1 rst = 1'b1;
    #1 check("rst_async_cnt", 64'(busy_cnt_o), 64'd0);
    check("rst_bypass_x5", rd(0), 64'hBAD);
    check("rst_busy_x6", 64'(rd_busy_o[1]), 64'd0);
    wr_valid_i = '0;
    #1 check("rst_array_x5", rd(0), 64'h0);
    check("rst_array_x12", rd(3), 64'h0);
    wr(0, 5, 64'hBAD);
    cyc();
    rst = 1'b0;
    idle();
    cyc();
    rsel(2, 8);
    #1 check("post_rst_x5", rd(0), 64'h0);
    check("post_rst_cnt", 64'(busy_cnt_o), 64'd0);
    check("post_rst_busy_x8", 64'(rd_busy_o[2]), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
